// File: rtl/gama_gen_pkg.sv
// Shared definitions for the gamma (branch metric) generator: frame length
// default, metric width, FSM state type, metric record and trellis parity.
package gama_pkg;

    localparam int FRAME_LEN_DEF = 16;
    localparam int MET_W         = 16;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    typedef logic signed [MET_W-1:0] metric_t;

    // One trellis step worth of metrics M(u,p); 64 bits when packed.
    typedef struct packed {
        metric_t m11;
        metric_t m10;
        metric_t m01;
        metric_t m00;
    } metric_set_t;

    // Parity bit of the 8-state RSC for state s = {d1,d2,d3} and input u.
    function automatic logic parity(input logic [2:0] s, input logic u);
        return u ^ s[2] ^ s[1];
    endfunction

    // Select M(u,p) out of a stored metric set.
    function automatic metric_t pick_metric(input metric_set_t m, input logic u, input logic p);
        metric_t r;
        case ({u, p})
            2'b00:   r = m.m00;
            2'b01:   r = m.m01;
            2'b10:   r = m.m10;
            default: r = m.m11;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gama_gen_if.sv
// Soft-input / gamma-output bundle of the gamma generator. The producer and
// consumer side (testbench or surrounding datapath) use the master modport,
// the generator itself uses the slave modport.
interface gama_gen_if #(
    parameter int FRAME_LEN = gama_pkg::FRAME_LEN_DEF,
    parameter int IN_W      = 8
);
    import gama_pkg::*;

    localparam int IDX_W = $clog2(FRAME_LEN);

    logic                   in_valid;
    logic                   in_ready;
    logic signed [IN_W-1:0] ys;
    logic signed [IN_W-1:0] yp;
    logic signed [IN_W-1:0] la;

    logic                   out_valid;
    logic                   out_ready;
    metric_t                g00, g01, g10, g11, g20, g21, g30, g31;
    metric_t                g40, g41, g50, g51, g60, g61, g70, g71;
    logic [IDX_W-1:0]       out_idx;
    logic                   frame_done;

    modport master (
        output in_valid, ys, yp, la, out_ready,
        input  in_ready, out_valid, out_idx, frame_done,
        input  g00, g01, g10, g11, g20, g21, g30, g31,
        input  g40, g41, g50, g51, g60, g61, g70, g71
    );

    modport slave (
        input  in_valid, ys, yp, la, out_ready,
        output in_ready, out_valid, out_idx, frame_done,
        output g00, g01, g10, g11, g20, g21, g30, g31,
        output g40, g41, g50, g51, g60, g61, g70, g71
    );

endinterface

// File: rtl/gama_gen_branch_calc.sv
// Combinational branch metric kernel: the four metrics
// M(u,p) = (u ? +1 : -1)*(ys+la) + (p ? +1 : -1)*yp at full 16-bit precision.
module gama_branch_calc
    import gama_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic signed [IN_W-1:0] ys_i,
    input  logic signed [IN_W-1:0] yp_i,
    input  logic signed [IN_W-1:0] la_i,
    output metric_set_t            met_o
);

    metric_t sys_w;
    metric_t par_w;

    // Sign-extend before adding so ys+la never wraps at the input width.
    assign sys_w = MET_W'(ys_i) + MET_W'(la_i);
    assign par_w = MET_W'(yp_i);

    assign met_o.m00 = -sys_w - par_w;
    assign met_o.m01 = -sys_w + par_w;
    assign met_o.m10 =  sys_w - par_w;
    assign met_o.m11 =  sys_w + par_w;

endmodule

// File: rtl/gama_gen.sv
// Gamma generator: collects one frame of soft-input triples, stores the four
// branch metrics per step, then presents the 16 per-state gammas in reverse
// step order for a backward recursion.
module gama_gen
    import gama_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int IN_W      = 8
) (
    input logic       clk,
    input logic       rst,
    gama_gen_if.slave bus
);

    localparam int               IDX_W    = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_e           state_q;
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_valid_q;
    logic             frame_done_q;
    metric_t          g_q [8][2];

    metric_t          g_d [8][2];
    metric_set_t      met_now;
    metric_set_t      rd_word_d;
    metric_set_t      buf_mem [FRAME_LEN];

    logic             in_ready;
    logic             in_fire;
    logic             out_fire;
    logic [IDX_W-1:0] rd_prev;

    gama_branch_calc #(
        .IN_W (IN_W)
    ) u_calc (
        .ys_i  (bus.ys),
        .yp_i  (bus.yp),
        .la_i  (bus.la),
        .met_o (met_now)
    );

    assign in_ready = (state_q == ST_FILL);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    assign rd_prev  = rd_idx_q - 1'b1;

    // Next gamma set: in FILL the only load is the last step of the frame,
    // which is taken straight from the kernel so the first set appears without
    // a bubble; in DRAIN the next lower step comes from the buffer.
    always_comb begin
        rd_word_d = (state_q == ST_FILL) ? met_now : buf_mem[rd_prev];
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                g_d[s][u] = pick_metric(rd_word_d, 1'(u), parity(3'(s), 1'(u)));
            end
        end
    end

    // Metric buffer, written at the fill index; contents survive reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_mem[wr_idx_q] <= met_now;
        end
    end

    // Fill/drain controller with registered handshake and gamma outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FILL;
            wr_idx_q     <= '0;
            rd_idx_q     <= LAST_IDX;
            out_idx_q    <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            g_q          <= '{default: '0};
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_FILL: begin
                    if (in_fire) begin
                        // Power-of-two frame length: the index wraps to 0 by itself.
                        wr_idx_q <= wr_idx_q + 1'b1;
                        if (wr_idx_q == LAST_IDX) begin
                            state_q     <= ST_DRAIN;
                            rd_idx_q    <= LAST_IDX;
                            out_idx_q   <= LAST_IDX;
                            out_valid_q <= 1'b1;
                            g_q         <= g_d;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (rd_idx_q == '0) begin
                            state_q      <= ST_FILL;
                            rd_idx_q     <= LAST_IDX;
                            out_valid_q  <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            rd_idx_q  <= rd_prev;
                            out_idx_q <= rd_prev;
                            g_q       <= g_d;
                        end
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.frame_done = frame_done_q;

    assign bus.g00 = g_q[0][0];
    assign bus.g01 = g_q[0][1];
    assign bus.g10 = g_q[1][0];
    assign bus.g11 = g_q[1][1];
    assign bus.g20 = g_q[2][0];
    assign bus.g21 = g_q[2][1];
    assign bus.g30 = g_q[3][0];
    assign bus.g31 = g_q[3][1];
    assign bus.g40 = g_q[4][0];
    assign bus.g41 = g_q[4][1];
    assign bus.g50 = g_q[5][0];
    assign bus.g51 = g_q[5][1];
    assign bus.g60 = g_q[6][0];
    assign bus.g61 = g_q[6][1];
    assign bus.g70 = g_q[7][0];
    assign bus.g71 = g_q[7][1];

endmodule

// File: doc/gama_gen.md
GAMA_GEN -- requirements
Module: gama_gen

Interface
REQ-001 Parameter FRAME_LEN, default 16, trellis steps per frame; power of 2, range 4..256.
REQ-002 Parameter IN_W, default 8, width of signed soft inputs ys/yp/la.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  soft-input triple valid.
REQ-006 in_ready  output  1  block accepts a triple; high only in FILL.
REQ-007 ys, yp, la  input  IN_W each, signed  systematic LLR, parity LLR, a-priori LLR.
REQ-008 out_valid  input-side handshake output  1  gamma set valid.
REQ-009 out_ready  input  1  consumer accepts gamma set.
REQ-010 g00,g01,g10,g11,...,g70,g71  output  16 each, signed  branch metric g<s><u> for trellis state s (0..7) and input bit u.
REQ-011 out_idx  output  log2(FRAME_LEN)  trellis step index of presented gamma set.
REQ-012 frame_done  output  1  one-cycle pulse after last gamma set of a frame is accepted.

Function
REQ-013 Trellis: 8-state RSC (feedback 1+D^2+D^3, feedforward 1+D+D^3), state s = {d1,d2,d3}, d1 = MSB; parity p(s,u) = u XOR s[2] XOR s[1].
REQ-014 Per step, four metrics SHALL be computed: M(u,p) = (u ? +1 : -1)*(ys+la) + (p ? +1 : -1)*yp, sign-extended to 16 bits, no truncation or saturation.
REQ-015 g<s><u> SHALL equal M(u, p(s,u)).
REQ-016 FSM states: FILL (reset state), DRAIN.
REQ-017 FILL: in_ready=1; each cycle with in_valid&&in_ready stores the four metrics at write index wr_idx, then wr_idx increments.
REQ-018 FILL -> DRAIN on the accept with wr_idx == FRAME_LEN-1; wr_idx wraps to 0.
REQ-019 DRAIN: in_ready=0; gamma sets are presented in reverse step order, FRAME_LEN-1 down to 0 (backward-recursion order).
REQ-020 out_valid SHALL rise on the first cycle after the FILL->DRAIN edge, with out_idx = FRAME_LEN-1 and the corresponding g outputs, all registered.
REQ-021 While out_valid && !out_ready, all g outputs and out_idx SHALL hold stable.
REQ-022 Each out_valid && out_ready handshake advances to the next lower index on the following cycle, with no bubble.
REQ-023 Handshake at out_idx 0: out_valid=0 and frame_done=1 on the next cycle; state returns to FILL with in_ready=1 that same cycle.
REQ-024 Back-to-back frames: the first accept of the next frame is possible on the cycle frame_done is high.
REQ-025 in_valid during DRAIN SHALL be ignored, with no storage and no state change.
REQ-026 Storage: FRAME_LEN x 64-bit buffer (four 16-bit metrics per step); the 16 outputs are mapped from the four stored metrics at read time.

Reset
REQ-027 rst asserted: state=FILL, wr_idx=0, rd index=FRAME_LEN-1, out_valid=0, frame_done=0, all g outputs=0, out_idx=0, effective immediately (asynchronous).
REQ-028 Reset mid-FILL or mid-DRAIN SHALL discard the partial frame; buffer contents need not be cleared.
REQ-029 First accept is possible on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package gama_pkg SHALL hold FRAME_LEN default, metric width 16, the FSM state enum, and the parity function p(s,u).
REQ-031 One combinational sub-module, gama_branch_calc, SHALL compute the four metrics M(u,p) from ys/yp/la; the FSM, buffer and output mapping stay in gama_gen.

Verification
REQ-032 Frame with ys=10, la=2, yp=-4 at step 0; after drain reaches idx 0: g00=-8, g01=8, g20=-16, g21=16.
REQ-033 FRAME_LEN=16 frame with ys=step index, yp=la=0, out_ready=1 continuously: out_idx sequence 15..0 on consecutive cycles; g01 sequence 15..0; frame_done one cycle after idx 0.
REQ-034 out_ready held low 5 cycles at idx 9: out_idx and g outputs stable for all 5 cycles; in_ready stays 0.
REQ-035 Extremes IN_W=8, ys=la=yp=-128: g00=384, g01=-384, with no overflow.
REQ-036 rst asserted after 7 accepts: in_ready=1 and out_valid=0 immediately; a fresh 16-step frame drains with only new data.
REQ-037 in_valid held high across frames: no accept during DRAIN; the next frame's first accept occurs on the frame_done cycle.
